// File: rtl/apogeo_pkg.sv
// Project-wide helpers shared across blocks.
// Circular-buffer pointers carry the index bits plus one wrap bit.
package apogeo_pkg;

    function automatic int burst_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/load_store_unit_pkg.sv
// Store-path types shared by the load/store unit and the burst buffer.
// Store data and tag widths here bound the DATA_WIDTH/TAG_WIDTH a buffer may use.
package load_store_unit_pkg;

    localparam int STORE_DATA_W = 32;
    localparam int STORE_TAG_W  = 6;

    typedef logic [STORE_DATA_W-1:0] store_data_t;
    typedef logic [STORE_TAG_W-1:0]  store_tag_t;

    typedef struct packed {
        store_data_t data;
        store_tag_t  tag;
    } burst_entry_t;

endpackage

// File: rtl/burst_buffer_memory.sv
// 1W1R entry array: registered data read (1 cycle, holds when idle), combinational tag peek.
// No backpressure; the owner guarantees write and read never target the same live slot.
module burst_buffer_memory
    import load_store_unit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [STORE_DATA_W-1:0] wr_data,
    input  logic [STORE_TAG_W-1:0]  wr_tag,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [STORE_DATA_W-1:0] rd_data,
    input  logic [AW-1:0]           tag_addr,
    output logic [STORE_TAG_W-1:0]  tag_data
);

    burst_entry_t mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= '{data: wr_data, tag: wr_tag};
        end
    end

    // Only the read register is reset; the array itself keeps stale contents.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr].data;
        end
    end

    assign tag_data = mem[tag_addr].tag;

endmodule

// File: rtl/spec_burst_buffer.sv
// Speculative store burst buffer: in-order tag-checked commit, flush drops uncommitted, pull drains committed (1-cycle).
// Push dropped while full; BURST_BUFFER_TIMEOUT_EN adds idle timeout that releases a partial burst.
module spec_burst_buffer
    import apogeo_pkg::*;
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BUFFER_DEPTH   = 16,
    parameter int TAG_WIDTH      = 6,
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            flush_i,
    input  logic                            push_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic [TAG_WIDTH-1:0]            tag_i,
    output logic                            full_o,
    input  logic                            commit_i,
    input  logic [TAG_WIDTH-1:0]            commit_tag_i,
    output logic                            commit_error_o,
    input  logic                            pull_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            valid_o,
    output logic [$clog2(BUFFER_DEPTH):0]   size_o,
    output logic [$clog2(BUFFER_DEPTH):0]   committed_o,
    output logic                            burst_ready_o
);

    localparam int PW = burst_ptr_width(BUFFER_DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(BUFFER_DEPTH);
    localparam logic [PW-1:0] BURST_P = PW'(BURST_LEN);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    logic [PW-1:0] push_ptr, commit_ptr, pull_ptr;
    logic [PW-1:0] push_ptr_nxt, commit_ptr_nxt;
    logic [PW-1:0] size_w, committed_w;
    logic          push_fire, commit_fire, pull_fire, commit_bad;
    logic          burst_full;
    logic          valid_q, commit_error_q;
    logic [STORE_DATA_W-1:0] rd_data;
    logic [STORE_TAG_W-1:0]  head_tag;

    assign size_w      = push_ptr - pull_ptr;
    assign committed_w = commit_ptr - pull_ptr;
    assign full_o      = (size_w == DEPTH_P);
    assign burst_full  = (committed_w >= BURST_P);

    always_comb begin
        push_fire      = push_i && !full_o;
        commit_fire    = commit_i && (commit_ptr != push_ptr);
        pull_fire      = pull_i && (committed_w != '0);
        commit_bad     = (commit_i && (commit_ptr == push_ptr))
                      || (commit_fire && (head_tag[TAG_WIDTH-1:0] != commit_tag_i));
        commit_ptr_nxt = commit_ptr;
        if (commit_fire) begin
            commit_ptr_nxt = commit_ptr + ONE_P;
        end
        // Flush rolls push back to the post-commit point, so a same-cycle commit survives.
        push_ptr_nxt = push_ptr;
        if (flush_i) begin
            push_ptr_nxt = commit_ptr_nxt;
        end else if (push_fire) begin
            push_ptr_nxt = push_ptr + ONE_P;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            push_ptr       <= '0;
            commit_ptr     <= '0;
            pull_ptr       <= '0;
            valid_q        <= 1'b0;
            commit_error_q <= 1'b0;
        end else begin
            push_ptr   <= push_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            valid_q    <= pull_fire;
            if (pull_fire) begin
                pull_ptr <= pull_ptr + ONE_P;
            end
            if (commit_bad) begin
                commit_error_q <= 1'b1;
            end
        end
    end

    burst_buffer_memory #(
        .DEPTH (BUFFER_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .wr_en    (push_fire && !flush_i),
        .wr_addr  (push_ptr[AW-1:0]),
        .wr_data  (STORE_DATA_W'(data_i)),
        .wr_tag   (STORE_TAG_W'(tag_i)),
        .rd_en    (pull_fire),
        .rd_addr  (pull_ptr[AW-1:0]),
        .rd_data  (rd_data),
        .tag_addr (commit_ptr[AW-1:0]),
        .tag_data (head_tag)
    );

    assign data_o         = rd_data[DATA_WIDTH-1:0];
    assign valid_o        = valid_q;
    assign commit_error_o = commit_error_q;
    assign size_o         = size_w;
    assign committed_o    = committed_w;

`ifdef BURST_BUFFER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_P  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt;
    logic          timeout_hit, partial, idle_inc;

    assign partial  = (committed_w != '0) && !burst_full;
    assign idle_inc = partial && !commit_fire;

    // The hit flag outlives counter clears from later commits until the partial state ends.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            idle_cnt    <= '0;
            timeout_hit <= 1'b0;
        end else begin
            if (!idle_inc) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TIMEOUT_P) begin
                idle_cnt <= idle_cnt + CW'(1);
            end
            if (!partial) begin
                timeout_hit <= 1'b0;
            end else if (idle_inc && (idle_cnt == TIMEOUT_M1)) begin
                timeout_hit <= 1'b1;
            end
        end
    end

    assign burst_ready_o = burst_full || (timeout_hit && (committed_w != '0));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign burst_ready_o  = burst_full;
`endif

endmodule

// File: doc/spec_burst_buffer.md
Name: spec_burst_buffer

Overview:
Parametrised successor to the external-memory burst buffer. It queues store data speculatively and tracks commit in order, one store per commit and checked by tag. On flush it discards uncommitted entries, and it drains only committed entries. It sits between the load/store unit's store path and the external memory interface. It raises burst_ready_o once a full burst of committed data is available.

Parameters:
DATA_WIDTH, 32, store data width in bits
BUFFER_DEPTH, 16, entries; must be a power of 2, at least 2
TAG_WIDTH, 6, store tag width
BURST_LEN, 4, committed entries required to assert burst_ready_o; 1..BUFFER_DEPTH
TIMEOUT_CYCLES, 64, idle cycles before a partial burst is released (optional feature only)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
flush_i  in  1  discard all uncommitted entries
push_i  in  1  push request
data_i  in  DATA_WIDTH  push data
tag_i  in  TAG_WIDTH  tag of pushed store
full_o  out  1  occupancy == BUFFER_DEPTH
commit_i  in  1  commit oldest uncommitted entry
commit_tag_i  in  TAG_WIDTH  expected tag of that entry
commit_error_o  out  1  sticky: tag mismatch or commit with nothing to commit
pull_i  in  1  pull request
data_o  out  DATA_WIDTH  pulled data, registered
valid_o  out  1  data_o valid, one-cycle pulse
size_o  out  $clog2(BUFFER_DEPTH)+1  total occupancy
committed_o  out  $clog2(BUFFER_DEPTH)+1  committed occupancy
burst_ready_o  out  1  committed_o >= BURST_LEN

Behaviour:
- Reset (rst_n_i low at a clock edge): all pointers 0; size_o=0, committed_o=0, full_o=0, valid_o=0, commit_error_o=0, burst_ready_o=0, data_o=0. Storage contents are not reset.
- Pointers: push, commit and pull pointers are each $clog2(BUFFER_DEPTH)+1 bits. The MSB is the wrap bit. Index = low bits. Arithmetic is modulo 2*BUFFER_DEPTH.
- Ordering invariant: pull_ptr <= commit_ptr <= push_ptr, in circular order.
- Push is accepted when push_i && !full_o. Data and tag are written at push_ptr, and push_ptr increments. A push while full is dropped; no state changes.
- Commit is accepted when commit_i and commit_ptr != push_ptr.
  - If tag[commit_ptr] != commit_tag_i, commit_error_o is set; commit_ptr still advances.
  - commit_i with nothing uncommitted sets commit_error_o; commit_ptr is unchanged.
  - commit_error_o clears only on reset.
- Pull is accepted when pull_i && committed_o != 0. On the next cycle data_o = entry[pull_ptr] and valid_o=1; pull_ptr increments.
  - Pull with committed_o == 0 is ignored: valid_o=0 and data_o holds.
  - Pull latency is 1 cycle.
- Flush: push_ptr <= commit_ptr after any same-cycle commit is applied, so a same-cycle commit survives.
  - A same-cycle push is discarded.
  - A same-cycle pull proceeds normally.
- Simultaneous push+pull while full: the pull frees its slot only in the next cycle, so the push is still rejected (full_o is evaluated from registered state).
- Simultaneous push+commit+pull on the same cycle are all legal. size_o = push_ptr - pull_ptr and committed_o = commit_ptr - pull_ptr, both computed from registered pointers.
- Reset mid-burst: all entries are lost; no partial valid_o.

Optional Feature:
Macro BURST_BUFFER_TIMEOUT_EN.
- Defined: a counter increments each cycle that 0 < committed_o < BURST_LEN and no commit is accepted. It clears otherwise.
  - When the counter reaches TIMEOUT_CYCLES, burst_ready_o asserts and stays asserted until committed_o == 0 or committed_o >= BURST_LEN.
  - Flush does not clear the counter.
  - Reset clears the counter.
- Not defined: burst_ready_o = (committed_o >= BURST_LEN) only; no counter logic is present.

Decomposition:
- load_store_unit_pkg gains typedef burst_entry_t {data, tag}, with widths from the package's store data and tag types.
- Shared constant BURST_PTR_WIDTH helper function in apogeo_pkg.
- One sub-module: burst_buffer_memory, a 1W1R synchronous array of burst_entry_t. It has a registered read port and a combinational tag read at commit_ptr.

Test Plan:
1. DEPTH=16, BURST_LEN=4: push 4 (tags 1..4), commit tags 1..4 -> burst_ready_o=1 after the 4th commit. Then 4 pulls -> valid_o pulses with data in push order.
2. Push 6, commit 2, flush -> size_o=2, committed_o=2. Push 1 more -> size_o=3. Pulls return only entries 0,1 before the new entry.
3. Fill 16 -> full_o=1. 17th push dropped and size_o stays 16. Push+pull same cycle while full -> push rejected, size_o=15 next cycle.
4. commit_tag_i=5 where stored tag=3 -> commit_error_o=1 and stays 1 through later correct commits until reset.
5. Wrap-around: 40 push/commit/pull cycles with DEPTH=16 -> data order preserved; size_o and committed_o correct across the pointer MSB toggle.
6. With BURST_BUFFER_TIMEOUT_EN, TIMEOUT_CYCLES=8: commit 1 entry, then idle -> burst_ready_o=1 on the 8th idle cycle. Pull -> burst_ready_o=0.
